// File: rtl/game_pkg.sv
// Shared tic-tac-toe definitions: board size, move-entry FSM states and a
// popcount helper used to validate button presses.
package game_pkg;

  localparam int NUM_CELLS  = 9;
  localparam int CELL_IDX_W = 4;
  localparam logic [CELL_IDX_W-1:0] MAX_MOVES = CELL_IDX_W'(NUM_CELLS);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE,
    LOCKED
  } move_state_t;

  function automatic logic [CELL_IDX_W-1:0] popcount(input logic [NUM_CELLS-1:0] v);
    logic [CELL_IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      n = n + CELL_IDX_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit 2-FF synchronizer followed by a debounce counter; the debounced
// level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic db
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The counter runs only while the synchronized sample disagrees with db.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_entry.sv
// Move-entry controller: debounces nine cell buttons and turns each valid
// press into one fixed-width one-hot strobe. Optional MOVE_ENTRY_MOVE_CNT_EN.
module move_entry
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STROBE_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CELLS-1:0]  btn,
  input  logic [NUM_CELLS-1:0]  occupied,
  input  logic                  game_over,
  output logic [NUM_CELLS-1:0]  cell_strobe,
  output logic                  reject,
  output logic                  busy
`ifdef MOVE_ENTRY_MOVE_CNT_EN
  ,
  output logic [CELL_IDX_W-1:0] move_count
`endif
);

  localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  logic [NUM_CELLS-1:0]  db;
  logic [NUM_CELLS-1:0]  db_q;
  logic [NUM_CELLS-1:0]  press_r;
  logic [CELL_IDX_W-1:0] press_cnt;
  logic                  press_any;
  logic                  press_good;
  logic [SCW-1:0]        scnt;
  move_state_t           state;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn[i]),
      .db     (db[i])
    );
  end

  // Rising edges of the debounced levels, registered so the FSM sees a clean pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q    <= '0;
      press_r <= '0;
    end else begin
      db_q    <= db;
      press_r <= db & ~db_q;
    end
  end

  assign press_cnt = popcount(press_r);
  assign press_any = |press_r;

`ifdef MOVE_ENTRY_MOVE_CNT_EN
  assign press_good = (press_cnt == CELL_IDX_W'(1)) && ((press_r & occupied) == '0)
                      && (move_count != MAX_MOVES);
`else
  assign press_good = (press_cnt == CELL_IDX_W'(1)) && ((press_r & occupied) == '0);
`endif

  // The strobe is loaded straight from the one-hot press, so it can only be zero or one-hot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cell_strobe <= '0;
      scnt        <= '0;
      reject      <= 1'b0;
      busy        <= 1'b0;
`ifdef MOVE_ENTRY_MOVE_CNT_EN
      move_count  <= '0;
`endif
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (game_over) begin
            state <= LOCKED;
            busy  <= 1'b1;
          end else if (press_good) begin
            state       <= ISSUE;
            cell_strobe <= press_r;
            scnt        <= SCW'(STROBE_CYCLES - 1);
            busy        <= 1'b1;
`ifdef MOVE_ENTRY_MOVE_CNT_EN
            if (move_count != MAX_MOVES) move_count <= move_count + 1'b1;
`endif
          end else if (press_any) begin
            state  <= RELEASE;
            reject <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ISSUE: begin
          if (scnt == '0) begin
            cell_strobe <= '0;
            state       <= RELEASE;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        RELEASE: begin
          if (game_over) begin
            state <= LOCKED;
          end else if (db == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOCKED: begin
          state <= LOCKED;
        end
        default: begin
          state       <= IDLE;
          cell_strobe <= '0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
